// File: rtl/qs_pkg.sv
// Shared qs definitions: data width plus the egress buffer entry and state types.
package qs_pkg;

  localparam int unsigned W = 16;
  typedef logic [W-1:0] w_t;

  localparam int unsigned EGRESS_DEPTH_DEFAULT = 64;

  typedef struct packed {
    logic err;
    logic eop;
    w_t   dat;
  } egress_entry_t;

  localparam int unsigned EGRESS_ENTRY_W = $bits(egress_entry_t);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PKT  = 2'd1,
    DROP = 2'd2
  } egress_state_t;

endpackage

// File: rtl/qs_egress_mem.sv
// Egress beat storage: flop array, one write port, asynchronous read port.
module qs_egress_mem
  import qs_pkg::*;
#(
  parameter  int unsigned DEPTH = EGRESS_DEPTH_DEFAULT,
  localparam int unsigned AW    = $clog2(DEPTH)
) (
  input  logic                      clk,
  input  logic                      we,
  input  logic [AW-1:0]             waddr,
  input  logic [EGRESS_ENTRY_W-1:0] wdata,
  input  logic [AW-1:0]             raddr,
  output logic [EGRESS_ENTRY_W-1:0] rdata
);

  logic [EGRESS_ENTRY_W-1:0] mem_q [DEPTH];

  // Write port; contents need no reset since pointers gate visibility.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  // Combinational read of the entry at the read pointer.
  always_comb begin
    rdata = mem_q[raddr];
  end

endmodule

// File: rtl/qs_egress.sv
// Packet store-and-forward buffer behind qs: whole packets are absorbed,
// committed on eop and replayed on a valid/ready interface. Packets that do
// not fit are dropped whole; framing violations are discarded and counted.
module qs_egress
  import qs_pkg::*;
#(
  parameter int unsigned DEPTH = EGRESS_DEPTH_DEFAULT,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_vld,
  input  logic             in_sop,
  input  logic             in_eop,
  input  logic             in_err,
  input  logic [W-1:0]     in_dat,
  output logic             out_vld_r,
  output logic             out_sop_r,
  output logic             out_eop_r,
  output logic             out_err_r,
  output logic [W-1:0]     out_dat_r,
  input  logic             out_rdy,
  output logic [CNT_W-1:0] drop_cnt_r,
  output logic [CNT_W-1:0] proto_cnt_r
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;
  localparam logic [PW-1:0] DEPTH_P = PW'(DEPTH);
  localparam logic [PW-1:0] ONE_P   = PW'(1);

  egress_state_t state_q, state_d;

  logic [PW-1:0] wr_ptr_q,  wr_ptr_d;
  logic [PW-1:0] cmt_ptr_q, cmt_ptr_d;
  logic [PW-1:0] rd_ptr_q,  rd_ptr_d;

  logic [CNT_W-1:0] drop_cnt_q,  drop_cnt_d;
  logic [CNT_W-1:0] proto_cnt_q, proto_cnt_d;

  logic         out_vld_q, out_vld_d;
  logic         out_sop_q, out_sop_d;
  logic         out_eop_q, out_eop_d;
  logic         out_err_q, out_err_d;
  logic [W-1:0] out_dat_q, out_dat_d;
  logic         sop_pend_q, sop_pend_d;

  logic          mem_we;
  logic [AW-1:0] mem_waddr;
  egress_entry_t mem_wdata;
  egress_entry_t mem_rdata;

  logic [PW-1:0] occ_wr;
  logic [PW-1:0] occ_cmt;
  logic          full_wr;
  logic          full_cmt;
  logic          drop_inc;
  logic          proto_inc;
  logic          avail;
  logic          load;

  qs_egress_mem #(
    .DEPTH (DEPTH)
  ) u_mem (
    .clk   (clk),
    .we    (mem_we),
    .waddr (mem_waddr),
    .wdata (mem_wdata),
    .raddr (rd_ptr_q[AW-1:0]),
    .rdata (mem_rdata)
  );

  // Occupancy from registered pointers; a slot freed by a pop is usable next cycle.
  always_comb begin
    occ_wr   = wr_ptr_q - rd_ptr_q;
    occ_cmt  = cmt_ptr_q - rd_ptr_q;
    full_wr  = (occ_wr == DEPTH_P);
    full_cmt = (occ_cmt == DEPTH_P);
  end

  // Write FSM: accept, commit, rewind or discard the incoming beat.
  always_comb begin
    state_d   = state_q;
    wr_ptr_d  = wr_ptr_q;
    cmt_ptr_d = cmt_ptr_q;
    mem_we    = 1'b0;
    mem_waddr = wr_ptr_q[AW-1:0];
    mem_wdata = '{err: in_err, eop: in_eop, dat: in_dat};
    drop_inc  = 1'b0;
    proto_inc = 1'b0;

    if (in_vld) begin
      if (in_sop) begin
        // Every sop restarts from the committed pointer: a rewind in PKT, a
        // no-op in IDLE/DROP where wr_ptr already equals cmt_ptr.
        if (state_q != IDLE) begin
          proto_inc = 1'b1;
        end
        wr_ptr_d = cmt_ptr_q;
        if (!full_cmt) begin
          mem_we    = 1'b1;
          mem_waddr = cmt_ptr_q[AW-1:0];
          wr_ptr_d  = cmt_ptr_q + ONE_P;
          if (in_eop) begin
            cmt_ptr_d = cmt_ptr_q + ONE_P;
            state_d   = IDLE;
          end else begin
            state_d = PKT;
          end
        end else begin
          drop_inc = 1'b1;
          state_d  = in_eop ? IDLE : DROP;
        end
      end else begin
        unique case (state_q)
          IDLE: begin
            proto_inc = 1'b1;
            state_d   = in_eop ? IDLE : DROP;
          end
          PKT: begin
            if (full_wr) begin
              wr_ptr_d = cmt_ptr_q;
              drop_inc = 1'b1;
              state_d  = in_eop ? IDLE : DROP;
            end else begin
              mem_we   = 1'b1;
              wr_ptr_d = wr_ptr_q + ONE_P;
              if (in_eop) begin
                cmt_ptr_d = wr_ptr_q + ONE_P;
                state_d   = IDLE;
              end
            end
          end
          DROP: begin
            if (in_eop) begin
              state_d = IDLE;
            end
          end
          default: state_d = IDLE;
        endcase
      end
    end
  end

  // Saturating statistics counters.
  always_comb begin
    drop_cnt_d  = drop_cnt_q;
    proto_cnt_d = proto_cnt_q;
    if (drop_inc && !(&drop_cnt_q)) begin
      drop_cnt_d = drop_cnt_q + CNT_W'(1);
    end
    if (proto_inc && !(&proto_cnt_q)) begin
      proto_cnt_d = proto_cnt_q + CNT_W'(1);
    end
  end

  // Output pipeline register fed from committed entries only.
  always_comb begin
    avail      = (rd_ptr_q != cmt_ptr_q);
    load       = (!out_vld_q || out_rdy) && avail;
    rd_ptr_d   = rd_ptr_q;
    out_vld_d  = out_vld_q;
    out_sop_d  = out_sop_q;
    out_eop_d  = out_eop_q;
    out_err_d  = out_err_q;
    out_dat_d  = out_dat_q;
    sop_pend_d = sop_pend_q;
    if (load) begin
      rd_ptr_d   = rd_ptr_q + ONE_P;
      out_vld_d  = 1'b1;
      out_sop_d  = sop_pend_q;
      out_eop_d  = mem_rdata.eop;
      out_err_d  = mem_rdata.err;
      out_dat_d  = mem_rdata.dat;
      sop_pend_d = mem_rdata.eop;
    end else if (out_rdy) begin
      out_vld_d = 1'b0;
    end
  end

  // State, pointer, counter and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      wr_ptr_q    <= '0;
      cmt_ptr_q   <= '0;
      rd_ptr_q    <= '0;
      drop_cnt_q  <= '0;
      proto_cnt_q <= '0;
      out_vld_q   <= 1'b0;
      out_sop_q   <= 1'b0;
      out_eop_q   <= 1'b0;
      out_err_q   <= 1'b0;
      out_dat_q   <= '0;
      sop_pend_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      cmt_ptr_q   <= cmt_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      drop_cnt_q  <= drop_cnt_d;
      proto_cnt_q <= proto_cnt_d;
      out_vld_q   <= out_vld_d;
      out_sop_q   <= out_sop_d;
      out_eop_q   <= out_eop_d;
      out_err_q   <= out_err_d;
      out_dat_q   <= out_dat_d;
      sop_pend_q  <= sop_pend_d;
    end
  end

  assign out_vld_r   = out_vld_q;
  assign out_sop_r   = out_sop_q;
  assign out_eop_r   = out_eop_q;
  assign out_err_r   = out_err_q;
  assign out_dat_r   = out_dat_q;
  assign drop_cnt_r  = drop_cnt_q;
  assign proto_cnt_r = proto_cnt_q;

endmodule

// File: tb/tb_qs_egress.sv
// Scoreboard bench for qs_egress with DEPTH=8: stimulus pushes expected
// output beats, a negedge monitor pops and compares on every transfer.
module tb_qs_egress;
  import qs_pkg::*;

  localparam int unsigned DEPTH = 8;
  localparam int unsigned CNT_W = 16;

  typedef struct packed {
    logic sop;
    logic eop;
    logic err;
    w_t   dat;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_vld, in_sop, in_eop, in_err;
  logic [W-1:0]     in_dat;
  logic             out_vld_r, out_sop_r, out_eop_r, out_err_r;
  logic [W-1:0]     out_dat_r;
  logic             out_rdy;
  logic [CNT_W-1:0] drop_cnt_r, proto_cnt_r;

  exp_t sb[$];
  int   vecs = 0;
  int   errs = 0;

  qs_egress #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_vld      (in_vld),
    .in_sop      (in_sop),
    .in_eop      (in_eop),
    .in_err      (in_err),
    .in_dat      (in_dat),
    .out_vld_r   (out_vld_r),
    .out_sop_r   (out_sop_r),
    .out_eop_r   (out_eop_r),
    .out_err_r   (out_err_r),
    .out_dat_r   (out_dat_r),
    .out_rdy     (out_rdy),
    .drop_cnt_r  (drop_cnt_r),
    .proto_cnt_r (proto_cnt_r)
  );

  always #5 clk = ~clk;

  // Monitor: every accepted output beat must match the head of the scoreboard.
  always @(negedge clk) begin
    if (!rst && out_vld_r && out_rdy) begin
      vecs++;
      if (sb.size() == 0) begin
        errs++;
        $display("FAIL out_beat unexpected: got sop=%0b eop=%0b err=%0b dat=%0h, none expected",
                 out_sop_r, out_eop_r, out_err_r, out_dat_r);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (out_sop_r !== e.sop || out_eop_r !== e.eop ||
            out_err_r !== e.err || out_dat_r !== e.dat) begin
          errs++;
          $display("FAIL out_beat: got sop=%0b eop=%0b err=%0b dat=%0h, exp sop=%0b eop=%0b err=%0b dat=%0h",
                   out_sop_r, out_eop_r, out_err_r, out_dat_r, e.sop, e.eop, e.err, e.dat);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h, exp %0h", name, act, exp);
    end
  endtask

  task automatic push(input logic sop, input logic eop, input logic err, input int d);
    sb.push_back('{sop: sop, eop: eop, err: err, dat: W'(d)});
  endtask

  // One input beat, consumed at the next rising edge.
  task automatic beat(input logic sop, input logic eop, input logic err, input int d);
    in_vld = 1'b1;
    in_sop = sop;
    in_eop = eop;
    in_err = err;
    in_dat = W'(d);
    @(posedge clk); #1;
    in_vld = 1'b0;
    in_sop = 1'b0;
    in_eop = 1'b0;
    in_err = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic do_reset();
    in_vld = 1'b0;
    rst    = 1'b1;
    @(posedge clk); #1;
    rst    = 1'b0;
  endtask

  // Bounded wait until every expected beat has been delivered.
  task automatic wait_drain();
    for (int i = 0; i < 200; i++) begin
      if (sb.size() == 0 && !out_vld_r) return;
      @(posedge clk); #1;
    end
    vecs++;
    errs++;
    $display("FAIL drain_timeout: got %0d beats outstanding, exp 0", sb.size());
  endtask

  initial begin
    rst = 1'b1; in_vld = 1'b0; in_sop = 1'b0; in_eop = 1'b0; in_err = 1'b0;
    in_dat = '0; out_rdy = 1'b0;
    idle(2);
    rst = 1'b0;

    check("rst_out_vld", 32'(out_vld_r), 0);
    check("rst_out_sop", 32'(out_sop_r), 0);
    check("rst_out_dat", 32'(out_dat_r), 0);
    check("rst_drop", 32'(drop_cnt_r), 0);
    check("rst_proto", 32'(proto_cnt_r), 0);

    // 1: single packet, first output two cycles after the eop beat.
    out_rdy = 1'b1;
    push(1, 0, 0, 5); push(0, 0, 0, 9); push(0, 1, 0, 12);
    beat(1, 0, 0, 5); beat(0, 0, 0, 9); beat(0, 1, 0, 12);
    check("lat_t1_vld", 32'(out_vld_r), 0);
    @(posedge clk); #1;
    check("lat_t2_vld", 32'(out_vld_r), 1);
    check("lat_t2_dat", 32'(out_dat_r), 5);
    wait_drain();

    // 2: two packets under stall; head beat held until release.
    out_rdy = 1'b0;
    push(1, 0, 0, 1); push(0, 0, 0, 2); push(0, 1, 0, 3);
    push(1, 0, 0, 4); push(0, 0, 0, 5); push(0, 1, 0, 6);
    beat(1, 0, 0, 1); beat(0, 0, 0, 2); beat(0, 1, 0, 3);
    beat(1, 0, 0, 4); beat(0, 0, 0, 5); beat(0, 1, 0, 6);
    for (int i = 0; i < 5; i++) begin
      check("stall_vld", 32'(out_vld_r), 1);
      check("stall_dat", 32'(out_dat_r), 1);
      check("stall_sop", 32'(out_sop_r), 1);
      idle(1);
    end
    check("stall_drop", 32'(drop_cnt_r), 0);
    out_rdy = 1'b1;
    wait_drain();

    // 3: overflow under stall. Register plus 8 entries hold 9 beats, so the
    // third packet carries a 4th beat to overflow and must be dropped whole.
    out_rdy = 1'b0;
    push(1, 0, 0, 1); push(0, 0, 0, 2); push(0, 1, 0, 3);
    push(1, 0, 0, 4); push(0, 0, 0, 5); push(0, 1, 0, 6);
    beat(1, 0, 0, 1); beat(0, 0, 0, 2); beat(0, 1, 0, 3);
    beat(1, 0, 0, 4); beat(0, 0, 0, 5); beat(0, 1, 0, 6);
    beat(1, 0, 0, 7); beat(0, 0, 0, 8); beat(0, 0, 0, 9); beat(0, 1, 0, 10);
    idle(2);
    check("ovf_drop", 32'(drop_cnt_r), 1);
    check("ovf_proto", 32'(proto_cnt_r), 0);
    out_rdy = 1'b1;
    wait_drain();
    push(1, 0, 0, 10); push(0, 1, 0, 11);
    beat(1, 0, 0, 10); beat(0, 1, 0, 11);
    wait_drain();

    // 4: framing errors.
    do_reset();
    check("rst2_drop", 32'(drop_cnt_r), 0);
    beat(1, 0, 0, 32'h20);
    for (int i = 1; i < 8; i++) beat(0, 0, 0, 32'h20 + i);
    beat(0, 1, 0, 32'h28);
    idle(5);
    check("long_drop", 32'(drop_cnt_r), 1);
    check("long_vld", 32'(out_vld_r), 0);
    beat(0, 1, 0, 32'h30);
    idle(1);
    check("nosop_proto", 32'(proto_cnt_r), 1);
    push(1, 0, 0, 7); push(0, 1, 0, 8);
    beat(1, 0, 0, 1); beat(0, 0, 0, 2);
    beat(1, 0, 0, 7); beat(0, 1, 0, 8);
    wait_drain();
    check("resop_proto", 32'(proto_cnt_r), 2);
    check("resop_drop", 32'(drop_cnt_r), 1);

    // 5: error flag travels with its own beat only.
    push(1, 0, 0, 3); push(0, 0, 1, 4); push(0, 1, 0, 5);
    beat(1, 0, 0, 3); beat(0, 0, 1, 4); beat(0, 1, 0, 5);
    wait_drain();

    // 6: reset mid-packet discards the partial packet and clears counters.
    beat(1, 0, 0, 32'h50); beat(0, 0, 0, 32'h51);
    do_reset();
    check("midrst_vld", 32'(out_vld_r), 0);
    check("midrst_drop", 32'(drop_cnt_r), 0);
    check("midrst_proto", 32'(proto_cnt_r), 0);
    push(1, 0, 0, 6); push(0, 1, 0, 7);
    beat(1, 0, 0, 6); beat(0, 1, 0, 7);
    wait_drain();
    idle(3);
    check("end_proto", 32'(proto_cnt_r), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
